// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the ARM datapath.
// Walks each instruction through FETCH/DECODE/EXECUTE-style states, owns the
// NZCV flags register, evaluates condition codes and drives every datapath
// control plus the memory request handshake.
//
// Memory handshake: MemReq is held high, with the address and store controls
// stable, until a cycle in which MemReady is high; the transfer completes on
// the rising clk edge at the end of that cycle. A request is never withdrawn
// before completion except by reset, which abandons it.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [3:0]  ALUControl,
    output logic        MemtoReg,
    output logic        linkSelect,
    output logic [2:0]  shiftOp,
    output logic        registerShift,
    output logic        storedCarry,
    output logic        Undef,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXECUTE  = 4'd2,
        S_ALUWB    = 4'd3,
        S_MEMADR   = 4'd4,
        S_MEMREAD  = 4'd5,
        S_MEMWB    = 4'd6,
        S_MEMWRITE = 4'd7,
        S_BRANCH   = 4'd8
    } state_t;

    localparam logic [2:0] SH_ROR  = 3'b011;
    localparam logic [2:0] SH_RRX  = 3'b100;
    localparam logic [2:0] SH_PASS = 3'b101;

    state_t      state;
    state_t      state_next;
    logic [3:0]  flags;      // {N,Z,C,V}
    logic        cond_pass;
    logic        is_compare;
    logic        unused_instr_bits;

    assign dbg_state   = state;
    assign storedCarry = flags[1];
    // TST/TEQ/CMP/CMN share the 10xx opcode group and have no writeback.
    assign is_compare  = (Instr[24:23] == 2'b10);
    // Register-number fields are routed by the datapath, not decoded here.
    assign unused_instr_bits = ^{Instr[19:12], Instr[3:0]};

    // State register; reset returns to FETCH and abandons any pending access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Architectural flags: loaded from the ALU at the end of an S-bit EXECUTE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              flags <= 4'b0000;
        else if (state == S_EXECUTE && Instr[20]) flags <= ALUFlags;
    end

    // ARM condition-code evaluation against the stored flags.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        cond_pass = 1'b0;
        case (Instr[31:28])
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (MemReady) state_next = S_DECODE;
            S_DECODE: begin
                if (!cond_pass) state_next = S_FETCH;
                else begin
                    case (Instr[27:26])
                        2'b00:   state_next = S_EXECUTE;
                        2'b01:   state_next = S_MEMADR;
                        2'b10:   state_next = S_BRANCH;
                        default: state_next = S_FETCH;
                    endcase
                end
            end
            S_EXECUTE:  state_next = is_compare ? S_FETCH : S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_MEMADR:   state_next = Instr[20] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (MemReady) state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Control outputs from state and Instr; enables are suppressed during reset.
    always_comb begin
        MemReq        = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCSrc         = 1'b0;
        RegWrite      = 1'b0;
        RegSrc        = 2'b00;
        ImmSrc        = 2'b00;
        ALUSrc        = 1'b0;
        ALUControl    = 4'b0000;
        MemtoReg      = 1'b0;
        linkSelect    = 1'b0;
        shiftOp       = 3'b000;
        registerShift = 1'b0;
        Undef         = 1'b0;
        case (state)
            S_FETCH: begin
                MemReq  = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: Undef = cond_pass && (Instr[27:26] == 2'b11);
            S_EXECUTE, S_ALUWB: begin
                ALUControl = Instr[24:21];
                ALUSrc     = Instr[25];
                if (Instr[25]) begin
                    shiftOp = SH_ROR;
                end else begin
                    registerShift = Instr[4];
                    // ROR #0 with an immediate shift amount encodes RRX.
                    if (Instr[6:5] == 2'b11 && Instr[11:7] == 5'd0 && !Instr[4])
                        shiftOp = SH_RRX;
                    else
                        shiftOp = {1'b0, Instr[6:5]};
                end
                RegWrite = (state == S_ALUWB);
            end
            S_MEMADR, S_MEMREAD, S_MEMWRITE: begin
                ALUSrc     = 1'b1;
                ImmSrc     = 2'b01;
                shiftOp    = SH_PASS;
                ALUControl = Instr[23] ? 4'b0100 : 4'b0010;
                if (state != S_MEMADR) begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                if (state == S_MEMWRITE) begin
                    MemWrite  = 1'b1;
                    RegSrc[1] = 1'b1;
                end
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                RegSrc[0]  = 1'b1;
                ImmSrc     = 2'b10;
                ALUSrc     = 1'b1;
                ALUControl = 4'b0100;
                shiftOp    = SH_PASS;
                PCWrite    = 1'b1;
                PCSrc      = 1'b1;
                linkSelect = Instr[24];
                RegWrite   = Instr[24];
            end
            default: ;
        endcase
        if (!reset) begin
            MemReq   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule
